ahb_decoder_dp: RTL and testbench



---
 rtl/ahb_decoder_dp.sv | 108 ++++++++++
 tb/tb_ahb_decoder_dp.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_decoder_dp.sv
// ahb_decoder_dp: AHB-Lite address decoder with data-phase response mux and an integrated default ERROR slave
module ahb_decoder_dp #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] i_start_addr,
    input  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] i_end_addr,
    input  logic [NUM_SLAVES-1:0]                 i_region_en,
    input  logic [ADDR_WIDTH-1:0]                 i_haddr,
    input  logic [1:0]                            i_htrans,
    input  logic                                  i_hready,
    input  logic [NUM_SLAVES-1:0]                 i_hreadyout_s,
    input  logic [NUM_SLAVES-1:0]                 i_hresp_s,
    input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] i_hrdata_s,
    input  logic                                  i_err_clr,
    output logic [NUM_SLAVES-1:0]                 o_hsel,
    output logic                                  o_hreadyout,
    output logic                                  o_hresp,
    output logic [DATA_WIDTH-1:0]                 o_hrdata,
    output logic [CNT_WIDTH-1:0]                  o_err_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

    state_t                r_state;
    logic                  r_dflt_rdy;
    logic                  r_dflt_resp;
    logic [NUM_SLAVES:0]   r_dp_sel;
    logic [CNT_WIDTH-1:0]  r_err_cnt;
    logic [NUM_SLAVES-1:0] w_hit;
    logic [NUM_SLAVES-1:0] w_hsel;
    logic                  w_miss;
    logic                  w_dflt_req;
    logic                  w_err_inc;
    logic                  w_s_rdy;
    logic                  w_s_resp;
    logic [DATA_WIDTH-1:0] w_s_rdata;
    logic                  w_unused_htrans;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            w_hit[i] = i_region_en[i] && i_start_addr[i] <= i_haddr && i_haddr <= i_end_addr[i];
    end

    // isolate the lowest set bit so the lowest-index region wins on overlap
    assign w_hsel          = w_hit & (~w_hit + NUM_SLAVES'(1));
    assign w_miss          = ~|w_hit;
    assign w_dflt_req      = i_hready && w_miss && i_htrans[1];
    assign w_err_inc       = w_dflt_req && r_state != S_ERR1;
    assign w_unused_htrans = i_htrans[0];
    assign o_hsel          = w_hsel;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_dflt_rdy  <= 1'b1;
            r_dflt_resp <= 1'b0;
        end else if (r_state == S_ERR1) begin
            r_state     <= S_ERR2;
            r_dflt_rdy  <= 1'b1;
            r_dflt_resp <= 1'b1;
        end else if (w_dflt_req) begin
            r_state     <= S_ERR1;
            r_dflt_rdy  <= 1'b0;
            r_dflt_resp <= 1'b1;
        end else begin
            r_state     <= S_IDLE;
            r_dflt_rdy  <= 1'b1;
            r_dflt_resp <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_dp_sel <= {1'b1, {NUM_SLAVES{1'b0}}};
        else if (i_hready)
            r_dp_sel <= {w_miss, w_hsel};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_err_clr)
            r_err_cnt <= '0;
        else if (w_err_inc && r_err_cnt != '1)
            r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
    end

    always_comb begin
        w_s_rdy   = 1'b0;
        w_s_resp  = 1'b0;
        w_s_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_dp_sel[i]) begin
                w_s_rdy   = i_hreadyout_s[i];
                w_s_resp  = i_hresp_s[i];
                w_s_rdata = i_hrdata_s[i];
            end
        end
    end

    assign o_hreadyout = r_dp_sel[NUM_SLAVES] ? r_dflt_rdy  : w_s_rdy;
    assign o_hresp     = r_dp_sel[NUM_SLAVES] ? r_dflt_resp : w_s_resp;
    assign o_hrdata    = w_s_rdata;
    assign o_err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_ahb_decoder_dp.sv
// tb_ahb_decoder_dp: table-driven decode checks plus a scoreboarded data-phase sequence
module tb_ahb_decoder_dp;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0][31:0] start_a, end_a;
    logic [1:0]       region_en;
    logic [31:0]      haddr;
    logic [1:0]       htrans;
    logic             hready;
    logic [1:0]       hreadyout_s, hresp_s;
    logic [1:0][31:0] hrdata_s;
    logic             err_clr;
    logic [1:0]       hsel, hsel_b;
    logic             o_rdy, o_resp, o_rdy_b, o_resp_b;
    logic [31:0]      o_rdata, o_rdata_b;
    logic [15:0]      err_cnt;
    logic [1:0]       err_cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    assign hready = o_rdy;

    ahb_decoder_dp u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_addr(start_a), .i_end_addr(end_a),
        .i_region_en(region_en), .i_haddr(haddr), .i_htrans(htrans), .i_hready(hready),
        .i_hreadyout_s(hreadyout_s), .i_hresp_s(hresp_s), .i_hrdata_s(hrdata_s),
        .i_err_clr(err_clr), .o_hsel(hsel), .o_hreadyout(o_rdy), .o_hresp(o_resp),
        .o_hrdata(o_rdata), .o_err_cnt(err_cnt)
    );

    ahb_decoder_dp #(.CNT_WIDTH(2)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_addr(start_a), .i_end_addr(end_a),
        .i_region_en(region_en), .i_haddr(haddr), .i_htrans(htrans), .i_hready(hready),
        .i_hreadyout_s(hreadyout_s), .i_hresp_s(hresp_s), .i_hrdata_s(hrdata_s),
        .i_err_clr(err_clr), .o_hsel(hsel_b), .o_hreadyout(o_rdy_b), .o_hresp(o_resp_b),
        .o_hrdata(o_rdata_b), .o_err_cnt(err_cnt_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  en;
        logic [31:0] addr;
        logic [1:0]  hsel;
    } dec_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [1:0]  rdy_s;
        logic [1:0]  rsp_s;
        logic        rst_n;
        logic        clr;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
        logic [15:0] e_cnt;
        logic [1:0]  e_sat;
    } seq_t;

    typedef struct {
        int          idx;
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        logic [15:0] cnt;
        logic [1:0]  sat;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("v%0d hreadyout", e.idx), {63'd0, o_rdy}, {63'd0, e.rdy});
            chk($sformatf("v%0d hresp", e.idx), {63'd0, o_resp}, {63'd0, e.resp});
            chk($sformatf("v%0d hrdata", e.idx), {32'd0, o_rdata}, {32'd0, e.data});
            chk($sformatf("v%0d err_cnt", e.idx), {48'd0, err_cnt}, {48'd0, e.cnt});
            chk($sformatf("v%0d err_cnt_sat", e.idx), {62'd0, err_cnt_b}, {62'd0, e.sat});
        end
    end

    dec_t dec[9];
    seq_t vec[22];

    initial begin
        dec[0] = '{2'b11, 32'h0900, 2'b01};
        dec[1] = '{2'b10, 32'h0900, 2'b10};
        dec[2] = '{2'b11, 32'h1FFF, 2'b10};
        dec[3] = '{2'b11, 32'h2000, 2'b00};
        dec[4] = '{2'b11, 32'h0000, 2'b01};
        dec[5] = '{2'b11, 32'h0FFF, 2'b01};
        dec[6] = '{2'b11, 32'h1000, 2'b10};
        dec[7] = '{2'b00, 32'h0900, 2'b00};
        dec[8] = '{2'b01, 32'h1000, 2'b00};

        vec[0]  = '{32'h1000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 2'd0};
        vec[1]  = '{32'h0100, 2'd2, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 16'd0, 2'd0};
        vec[2]  = '{32'h0100, 2'd2, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 16'd0, 2'd0};
        vec[3]  = '{32'h0100, 2'd2, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 16'd0, 2'd0};
        vec[4]  = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11111111, 16'd0, 2'd0};
        vec[5]  = '{32'h3004, 2'd3, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        16'd1, 2'd1};
        vec[6]  = '{32'h3004, 2'd3, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        16'd1, 2'd1};
        vec[7]  = '{32'h3000, 2'd0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        16'd2, 2'd2};
        vec[8]  = '{32'h3000, 2'd0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        16'd2, 2'd2};
        vec[9]  = '{32'h3000, 2'd1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        16'd2, 2'd2};
        vec[10] = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        16'd2, 2'd2};
        vec[11] = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        16'd3, 2'd3};
        vec[12] = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        16'd3, 2'd3};
        vec[13] = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        16'd4, 2'd3};
        vec[14] = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        16'd4, 2'd3};
        vec[15] = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        16'd5, 2'd3};
        vec[16] = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        16'd5, 2'd3};
        vec[17] = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        16'd0, 2'd0};
        vec[18] = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        16'd0, 2'd0};
        vec[19] = '{32'h3000, 2'd2, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        16'd1, 2'd1};
        vec[20] = '{32'h3000, 2'd0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 2'd0};
        vec[21] = '{32'h3000, 2'd0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 2'd0};

        start_a     = '{32'h0800, 32'h0000};
        end_a       = '{32'h1FFF, 32'h0FFF};
        region_en   = 2'b11;
        haddr       = 32'h3000;
        htrans      = 2'd2;
        hreadyout_s = 2'b11;
        hresp_s     = 2'b00;
        hrdata_s    = '{32'hA5A5A5A5, 32'h11111111};
        err_clr     = 1'b0;
        rst_n       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset hreadyout", {63'd0, o_rdy}, 64'd1);
        chk("reset hresp", {63'd0, o_resp}, 64'd0);
        chk("reset hrdata", {32'd0, o_rdata}, 64'd0);
        chk("reset err_cnt", {48'd0, err_cnt}, 64'd0);
        rst_n  = 1'b1;
        htrans = 2'd0;

        for (int d = 0; d < 9; d++) begin
            region_en = dec[d].en;
            haddr     = dec[d].addr;
            #1;
            chk($sformatf("dec%0d hsel", d), {62'd0, hsel}, {62'd0, dec[d].hsel});
        end
        region_en = 2'b11;
        start_a[1] = 32'h3000;
        end_a[1]   = 32'h2000;
        haddr      = 32'h2800;
        #1;
        chk("inverted region hsel", {62'd0, hsel}, 64'd0);
        haddr = 32'h3000;
        #1;
        chk("inverted region start hsel", {62'd0, hsel}, 64'd0);
        start_a[1] = 32'h0800;
        end_a[1]   = 32'h1FFF;

        for (int v = 0; v < 22; v++) begin
            @(posedge clk);
            #1;
            haddr       = vec[v].addr;
            htrans      = vec[v].trans;
            hreadyout_s = vec[v].rdy_s;
            hresp_s     = vec[v].rsp_s;
            rst_n       = vec[v].rst_n;
            err_clr     = vec[v].clr;
            sb.push_back('{v, vec[v].e_rdy, vec[v].e_resp, vec[v].e_data, vec[v].e_cnt, vec[v].e_sat});
        end

        for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
